// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the debounced button level into single-cycle events: press, release,
// short click, long press and (optionally) auto-repeat, plus a held level and
// a wrapping press counter. All outputs are registered.
//
// Optional feature: define BUTTON_EVENT_REPEAT_EN to enable auto-repeat pulses
// while the button stays held after a long press. Without it, repeat_pulse is
// constant 0 and the hold counter rests at 0 in the LONG state.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = $clog2(LONG_CYCLES + REPEAT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debounced_signal,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       pressed_level,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    // Hold count value at which the long threshold is reached.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    logic             btn_q;
    logic             press_next;
    logic             release_next;
    logic             short_next;
    logic             long_next;
    logic             repeat_next;
    logic             level_next;
    logic [7:0]       press_count_next;

    // Register state, counters and all outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            btn_q         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            pressed_level <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_cnt_next;
            btn_q         <= debounced_signal;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            short_pulse   <= short_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            pressed_level <= level_next;
            press_count   <= press_count_next;
        end
    end

    // Next-state decision from the current state and the sampled level.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (debounced_signal && !btn_q) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!debounced_signal) begin
                    state_next = IDLE;
                end else if (hold_cnt == LONG_LAST) begin
                    state_next = LONG;
                end
            end
            LONG: begin
                if (!debounced_signal) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulse, hold-counter and press-counter values to load at this edge.
    always_comb begin
        press_next       = 1'b0;
        release_next     = 1'b0;
        short_next       = 1'b0;
        long_next        = 1'b0;
        repeat_next      = 1'b0;
        hold_cnt_next    = hold_cnt;
        press_count_next = press_count;
        case (state)
            IDLE: begin
                if (debounced_signal && !btn_q) begin
                    // The press edge itself is the first high sample counted.
                    press_next       = 1'b1;
                    hold_cnt_next    = CNT_W'(1);
                    press_count_next = press_count + 8'd1;
                end else begin
                    hold_cnt_next = '0;
                end
            end
            PRESSED: begin
                if (!debounced_signal) begin
                    // A release at the threshold edge still counts as short.
                    release_next  = 1'b1;
                    short_next    = 1'b1;
                    hold_cnt_next = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    long_next     = 1'b1;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + CNT_W'(1);
                end
            end
            LONG: begin
                if (!debounced_signal) begin
                    release_next  = 1'b1;
                    hold_cnt_next = '0;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (hold_cnt == REPEAT_LAST) begin
                        repeat_next   = 1'b1;
                        hold_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt + CNT_W'(1);
                    end
`else
                    hold_cnt_next = '0;
`endif
                end
            end
            default: begin
                hold_cnt_next = '0;
            end
        endcase
        level_next = (state_next != IDLE);
    end

endmodule
